// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - RV32I execute-stage issuer driving ALU operands/control into writeback or branch redirect
module alu_op_issuer #(
    parameter int XLEN       = 32,
    parameter bit SHAMT_MASK = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    output logic [XLEN-1:0] ex_scr_a,
    output logic [XLEN-1:0] ex_scr_b,
    output logic [3:0]      ex_alu_control,
    output logic [1:0]      ex_equal_comp,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero,
    input  logic            wb_ready,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            ill_instr
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_BR    = 2'd2;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] ex_scr_a_q, ex_scr_b_q, ex_target_q;
    logic [3:0]      ex_alu_control_q;
    logic [1:0]      ex_equal_comp_q;
    logic [4:0]      ex_rd_q;
    logic            ex_branch_q;
    logic            wb_valid_q, br_taken_q, ill_instr_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q, br_target_q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_u, imm_b;
    logic            dec_ok, dec_branch, dec_shift;
    logic [3:0]      dec_ctrl;
    logic [1:0]      dec_eq;
    logic [XLEN-1:0] dec_a, dec_b;
    logic            accept, load, retire;

    // SUB only exists in the register form; for OP-IMM bit 30 is immediate data.
    function automatic logic [3:0] f3_ctrl(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            3'b000:  f3_ctrl = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  f3_ctrl = ALU_SLL;
            3'b010:  f3_ctrl = ALU_SLT;
            3'b011:  f3_ctrl = ALU_SLTU;
            3'b100:  f3_ctrl = ALU_XOR;
            3'b101:  f3_ctrl = alt ? ALU_SRA : ALU_SRL;
            3'b110:  f3_ctrl = ALU_OR;
            default: f3_ctrl = ALU_AND;
        endcase
    endfunction

    assign opcode = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign imm_i  = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
    assign imm_u  = {id_instr[31:12], 12'b0};
    assign imm_b  = {{(XLEN-12){id_instr[31]}}, id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};

    always_comb begin
        dec_ok     = 1'b1;
        dec_branch = 1'b0;
        dec_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
        dec_ctrl   = ALU_ADD;
        dec_eq     = 2'b00;
        dec_a      = id_rs1_data;
        dec_b      = id_rs2_data;
        case (opcode)
            OPC_OP: begin
                dec_ctrl = f3_ctrl(funct3, id_instr[30], 1'b1);
            end
            OPC_OP_IMM: begin
                dec_ctrl = f3_ctrl(funct3, id_instr[30], 1'b0);
                dec_b    = dec_shift ? {{(XLEN-5){1'b0}}, id_instr[24:20]} : imm_i;
            end
            OPC_LUI: begin
                dec_shift = 1'b0;
                dec_a     = '0;
                dec_b     = imm_u;
            end
            OPC_AUIPC: begin
                dec_shift = 1'b0;
                dec_a     = id_pc;
                dec_b     = imm_u;
            end
            OPC_BRANCH: begin
                dec_shift  = 1'b0;
                dec_branch = 1'b1;
                dec_ok     = (funct3[2:1] != 2'b01);
                dec_eq     = {~funct3[0], 1'b1};
                case (funct3[2:1])
                    2'b00:   dec_ctrl = ALU_XOR;
                    2'b10:   dec_ctrl = ALU_SLT;
                    default: dec_ctrl = ALU_SLTU;
                endcase
            end
            default: begin
                dec_ok    = 1'b0;
                dec_shift = 1'b0;
            end
        endcase
        if (SHAMT_MASK && dec_shift) begin
            dec_b = {{(XLEN-5){1'b0}}, dec_b[4:0]};
        end
    end

    assign retire   = (state_q == ST_HOLD) && !ex_branch_q && wb_ready;
    assign id_ready = (state_q == ST_EMPTY) || retire;
    assign accept   = id_valid && id_ready;
    assign load     = accept && dec_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_HOLD;
            ST_HOLD: begin
                if (ex_branch_q) begin
                    state_d = ST_BR;
                end else if (wb_ready) begin
                    state_d = load ? ST_HOLD : ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= ST_EMPTY;
            ex_scr_a_q       <= '0;
            ex_scr_b_q       <= '0;
            ex_target_q      <= '0;
            ex_alu_control_q <= '0;
            ex_equal_comp_q  <= '0;
            ex_rd_q          <= '0;
            ex_branch_q      <= 1'b0;
            wb_valid_q       <= 1'b0;
            wb_rd_q          <= '0;
            wb_data_q        <= '0;
            br_taken_q       <= 1'b0;
            br_target_q      <= '0;
            ill_instr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= 1'b0;
            br_taken_q  <= 1'b0;
            ill_instr_q <= accept && !dec_ok;
            if (retire) begin
                wb_valid_q <= (ex_rd_q != 5'd0);
                wb_rd_q    <= ex_rd_q;
                wb_data_q  <= alu_result;
            end
            // The branch condition is sampled on the HOLD->BR edge and redirected during BR.
            if ((state_q == ST_HOLD) && ex_branch_q) begin
                br_taken_q  <= alu_zero;
                br_target_q <= ex_target_q;
            end
            if (load) begin
                ex_scr_a_q       <= dec_a;
                ex_scr_b_q       <= dec_b;
                ex_target_q      <= id_pc + imm_b;
                ex_alu_control_q <= dec_ctrl;
                ex_equal_comp_q  <= dec_eq;
                ex_rd_q          <= id_instr[11:7];
                ex_branch_q      <= dec_branch;
            end
        end
    end

    assign ex_scr_a       = ex_scr_a_q;
    assign ex_scr_b       = ex_scr_b_q;
    assign ex_alu_control = ex_alu_control_q;
    assign ex_equal_comp  = ex_equal_comp_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign br_taken       = br_taken_q;
    assign br_target      = br_target_q;
    assign ill_instr      = ill_instr_q;
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb/tb_alu_op_issuer.sv - directed and randomized bench for alu_op_issuer against a field-level decode model
module tb_alu_op_issuer;
    logic        clk = 1'b0;
    logic        rst_n, id_valid, id_ready, alu_zero, wb_ready, wb_valid, br_taken, ill_instr;
    logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data, ex_scr_a, ex_scr_b, alu_result;
    logic [31:0] wb_data, br_target;
    logic [3:0]  ex_alu_control;
    logic [1:0]  ex_equal_comp;
    logic [4:0]  wb_rd;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    alu_op_issuer #(.XLEN(32), .SHAMT_MASK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .ex_scr_a(ex_scr_a),
        .ex_scr_b(ex_scr_b), .ex_alu_control(ex_alu_control), .ex_equal_comp(ex_equal_comp),
        .alu_result(alu_result), .alu_zero(alu_zero), .wb_ready(wb_ready), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data), .br_taken(br_taken), .br_target(br_target), .ill_instr(ill_instr)
    );

    // ALU code per funct3, lowest nibble = funct3 0: ADD SLL SLT SLTU XOR SRL OR AND
    localparam logic [31:0] F3_CODES = 32'h0183_7542;

    typedef struct packed {
        logic        legal;
        logic        is_br;
        logic [3:0]  ctrl;
        logic [1:0]  eq;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] target;
        logic [4:0]  rd;
    } exp_t;

    function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t        e;
        logic [2:0]  f3;
        logic [31:0] imm_b;
        logic        shift;
        f3    = instr[14:12];
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        imm_b = (32'(instr[11:8]) << 1) | (32'(instr[30:25]) << 5) | (32'(instr[7]) << 11)
              | (instr[31] ? 32'hFFFF_F000 : 32'h0);
        e        = '0;
        e.legal  = 1'b1;
        e.rd     = instr[11:7];
        e.target = pc + imm_b;
        e.ctrl   = F3_CODES[{f3, 2'b00} +: 4];
        e.a      = rs1;
        e.b      = rs2;
        case (instr[6:0])
            7'h33: begin
                if (f3 == 3'd0 && instr[30]) e.ctrl = 4'b0110;
                if (f3 == 3'd5 && instr[30]) e.ctrl = 4'b1001;
                if (shift) e.b = rs2 % 32;
            end
            7'h13: begin
                e.b = 32'($signed(instr) >>> 20);
                if (f3 == 3'd5 && instr[30]) e.ctrl = 4'b1001;
                if (shift) e.b = 32'(instr[24:20]);
            end
            7'h37: begin e.ctrl = 4'b0010; e.a = 32'h0; e.b = instr & 32'hFFFF_F000; end
            7'h17: begin e.ctrl = 4'b0010; e.a = pc;    e.b = instr & 32'hFFFF_F000; end
            7'h63: begin
                e.is_br = 1'b1;
                e.legal = (f3 != 3'd2) && (f3 != 3'd3);
                e.ctrl  = (f3 < 3'd4) ? 4'b0011 : (f3 < 3'd6) ? 4'b0101 : 4'b0111;
                e.eq    = f3[0] ? 2'b01 : 2'b11;
            end
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ex(input string tag, input exp_t e);
        chk({tag, ".ctrl"}, 32'(ex_alu_control), 32'(e.ctrl));
        chk({tag, ".eq"},   32'(ex_equal_comp),  32'(e.eq));
        chk({tag, ".a"},    ex_scr_a, e.a);
        chk({tag, ".b"},    ex_scr_b, e.b);
    endtask

    // Offers one instruction from EMPTY and follows it to retirement, redirect or drop.
    task automatic run_op(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] res,
                          input logic zero, input int stall);
        exp_t e;
        e = ref_decode(instr, pc, rs1, rs2);
        id_instr = instr; id_pc = pc; id_rs1_data = rs1; id_rs2_data = rs2;
        id_valid = 1'b1;
        wb_ready = (stall == 0);
        #1 chk({tag, ".rdy_empty"}, 32'(id_ready), 32'd1);
        tick();
        id_valid = 1'b0;
        chk({tag, ".ill"}, 32'(ill_instr), 32'(!e.legal));
        if (!e.legal) begin
            chk({tag, ".rdy_ill"}, 32'(id_ready), 32'd1);
            tick();
            chk({tag, ".ill_clr"}, 32'(ill_instr), 32'd0);
            chk({tag, ".ill_nowb"}, 32'(wb_valid), 32'd0);
        end else if (e.is_br) begin
            check_ex(tag, e);
            alu_zero = zero;
            #1 chk({tag, ".rdy_hold"}, 32'(id_ready), 32'd0);
            tick();
            chk({tag, ".br_taken"}, 32'(br_taken), 32'(zero));
            if (zero) chk({tag, ".br_target"}, br_target, e.target);
            chk({tag, ".br_nowb"}, 32'(wb_valid), 32'd0);
            id_valid = 1'b1;
            id_instr = 32'h0000_0033 | (32'($urandom_range(1, 31)) << 7);
            #1 chk({tag, ".rdy_br"}, 32'(id_ready), 32'd0);
            tick();
            id_valid = 1'b0;
            chk({tag, ".br_clr"}, 32'(br_taken), 32'd0);
            chk({tag, ".wrongpath_nowb"}, 32'(wb_valid), 32'd0);
            chk({tag, ".rdy_after"}, 32'(id_ready), 32'd1);
        end else begin
            check_ex(tag, e);
            alu_result = res;
            for (int i = 0; i < stall; i++) begin
                chk({tag, ".rdy_stall"}, 32'(id_ready), 32'd0);
                tick();
                check_ex({tag, ".stall"}, e);
                chk({tag, ".stall_nowb"}, 32'(wb_valid), 32'd0);
            end
            wb_ready = 1'b1;
            #1 chk({tag, ".rdy_retire"}, 32'(id_ready), 32'd1);
            tick();
            chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(e.rd != 5'd0));
            if (e.rd != 5'd0) begin
                chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(e.rd));
                chk({tag, ".wb_data"}, wb_data, res);
            end
            tick();
            chk({tag, ".wb_clr"}, 32'(wb_valid), 32'd0);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd7, 5'd5, f3, rd, 7'h33};
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, ".a"}, ex_scr_a, 32'd0);
        chk({tag, ".b"}, ex_scr_b, 32'd0);
        chk({tag, ".ctrl"}, 32'(ex_alu_control), 32'd0);
        chk({tag, ".eq"}, 32'(ex_equal_comp), 32'd0);
        chk({tag, ".wbv"}, 32'(wb_valid), 32'd0);
        chk({tag, ".wbrd"}, 32'(wb_rd), 32'd0);
        chk({tag, ".wbd"}, wb_data, 32'd0);
        chk({tag, ".brt"}, 32'(br_taken), 32'd0);
        chk({tag, ".brtg"}, br_target, 32'd0);
        chk({tag, ".ill"}, 32'(ill_instr), 32'd0);
        chk({tag, ".rdy"}, 32'(id_ready), 32'd1);
    endtask

    localparam logic [6:0] OPS [5] = '{7'h33, 7'h13, 7'h63, 7'h37, 7'h17};

    initial begin
        logic [31:0] instr;
        rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0;
        alu_result = '0; alu_zero = 1'b0; wb_ready = 1'b1;
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        run_op("add", rtype(7'h00, 3'b000, 5'd3), 32'h40, 32'd5, 32'd7, 32'd12, 1'b0, 0);
        id_instr = rtype(7'h00, 3'b000, 5'd3); id_valid = 1'b1; wb_ready = 1'b0;
        tick(); id_valid = 1'b0;
        chk("add.ctrl_const", 32'(ex_alu_control), 32'b0010);
        wb_ready = 1'b1; alu_result = 32'd12;
        tick(); tick();
        run_op("sub", rtype(7'h20, 3'b000, 5'd9), 32'h44, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 0);
        run_op("beq", {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b0, 7'h63}, 32'h100, 32'h11, 32'h11, 32'h0, 1'b1, 0);
        chk("beq.target_const", br_target, 32'h110);
        run_op("bgeu", {1'b1, 6'h3F, 5'd2, 5'd1, 3'b111, 4'b1100, 1'b1, 7'h63}, 32'h200, 32'h1, 32'h9, 32'h0, 1'b0, 0);
        run_op("sra", rtype(7'h20, 3'b101, 5'd4), 32'h48, 32'h8000_0000, 32'hFFFF_FFE1, 32'hC000_0000, 1'b0, 0);
        run_op("srai", {7'h20, 5'd31, 5'd1, 3'b101, 5'd6, 7'h13}, 32'h4C, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 1'b0, 0);
        run_op("addi_neg", {12'hFF0, 5'd1, 3'b000, 5'd6, 7'h13}, 32'h50, 32'd100, 32'h0, 32'd84, 1'b0, 0);
        run_op("lui", {20'hABCDE, 5'd8, 7'h37}, 32'h54, 32'h1, 32'h2, 32'hABCD_E000, 1'b0, 0);
        run_op("auipc", {20'h00001, 5'd8, 7'h17}, 32'h58, 32'h1, 32'h2, 32'h0000_1058, 1'b0, 0);
        run_op("rd0", rtype(7'h00, 3'b110, 5'd0), 32'h5C, 32'hF0, 32'h0F, 32'hFF, 1'b0, 0);
        run_op("stall3", rtype(7'h00, 3'b000, 5'd10), 32'h60, 32'd1, 32'd2, 32'd3, 1'b0, 3);
        run_op("ill_opc", 32'h0000_007F, 32'h64, 32'h0, 32'h0, 32'h0, 1'b0, 0);
        run_op("ill_br010", {7'h0, 5'd2, 5'd1, 3'b010, 5'd0, 7'h63}, 32'h68, 32'h0, 32'h0, 32'h0, 1'b0, 0);

        id_instr = rtype(7'h00, 3'b000, 5'd11); id_rs1_data = 32'd1; id_rs2_data = 32'd1;
        id_valid = 1'b1; wb_ready = 1'b1;
        tick();
        alu_result = 32'hAAAA_0001;
        id_instr = rtype(7'h00, 3'b100, 5'd12); id_rs1_data = 32'h55; id_rs2_data = 32'hAA;
        #1 chk("b2b.rdy", 32'(id_ready), 32'd1);
        tick();
        id_valid = 1'b0;
        chk("b2b.wbv1", 32'(wb_valid), 32'd1);
        chk("b2b.wbd1", wb_data, 32'hAAAA_0001);
        chk("b2b.ctrl2", 32'(ex_alu_control), 32'b0011);
        alu_result = 32'h0000_00FF;
        tick();
        chk("b2b.wbv2", 32'(wb_valid), 32'd1);
        chk("b2b.wbrd2", 32'(wb_rd), 32'd12);
        chk("b2b.wbd2", wb_data, 32'h0000_00FF);
        tick();

        id_instr = rtype(7'h00, 3'b000, 5'd4); id_valid = 1'b1; wb_ready = 1'b0; alu_result = 32'd77;
        tick(); id_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_all_zero("rst_stall");
        rst_n = 1'b1; wb_ready = 1'b1;
        tick();
        chk("rst_stall.nowb1", 32'(wb_valid), 32'd0);
        tick();
        chk("rst_stall.nowb2", 32'(wb_valid), 32'd0);

        for (int n = 0; n < 40; n++) begin
            instr = $urandom;
            if ($urandom_range(0, 9) == 0) instr[6:0] = 7'($urandom);
            else instr[6:0] = OPS[$urandom_range(0, 4)];
            run_op("rand", instr, $urandom, $urandom, $urandom, $urandom, 1'($urandom), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
